booth_multiplier: RTL and testbench
===================================

BOOTH_MULTIPLIER -- requirements
Module: booth_multiplier

Interface
REQ-001 Parameter WIDTH, default 32, operand width in bits; legal range 4..64.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request a multiply; sampled only in IDLE.
REQ-005 is_signed  input  1  1 = two's-complement operands, 0 = unsigned; sampled with start.
REQ-006 mult_cand  input  WIDTH  multiplicand; sampled with start.
REQ-007 multiplier  input  WIDTH  multiplier; sampled with start.
REQ-008 busy  output  1  high while an operation is in flight (RUN or DONE).
REQ-009 ready  output  1  one-cycle pulse when the result becomes valid.
REQ-010 result_lo  output  WIDTH  low half of the 2*WIDTH product.
REQ-011 result_hi  output  WIDTH  high half of the 2*WIDTH product.
REQ-012 overflow  output  1  product not representable in WIDTH bits in the sampled mode.

Function
REQ-013 FSM states are IDLE, RUN and DONE; transitions IDLE->RUN on start, RUN->DONE after the final step, DONE->IDLE unconditionally.
REQ-014 On acceptance, operands extend to WIDTH+1 bits (sign-extended if is_signed, else zero-extended); the radix-2 Booth recoder sees bit pair {q0, q_-1} with q_-1=0.
REQ-015 Each RUN cycle performs one Booth step: 10 -> subtract extended multiplicand, 01 -> add it, 00/11 -> no add; then arithmetic right shift of the {acc, q, q_-1} register by 1.
REQ-016 RUN lasts exactly WIDTH+1 cycles, counted by an internal step counter of ceil(log2(WIDTH+2)) bits.
REQ-017 ready is high for exactly one cycle, in DONE, which is the (WIDTH+2)th cycle after the start edge.
REQ-018 result_lo, result_hi and overflow update only on entry to DONE and hold until the next DONE or reset.
REQ-019 Signed overflow = result_hi != {WIDTH{result_lo[WIDTH-1]}}; unsigned overflow = result_hi != 0.
REQ-020 start while busy is ignored, and operand/mode changes while busy have no effect.
REQ-021 start in the same cycle as DONE is ignored; start is accepted again from the following IDLE cycle.
REQ-022 Holding start high continuously yields back-to-back operations with one IDLE cycle between them.

Reset
REQ-023 reset forces IDLE, clears the step counter and Booth register, and drives busy=0, ready=0, result_lo=0, result_hi=0, overflow=0 on the following edge.
REQ-024 reset during RUN or DONE aborts the operation with no ready pulse; reset overrides a simultaneous start.

Configuration
REQ-025 Macro BOOTH_ZERO_SKIP_EN: when defined, a start with either operand equal to zero skips RUN (IDLE->DONE), so ready occurs on the first cycle after the start edge and results are all zero with overflow=0.
REQ-026 When BOOTH_ZERO_SKIP_EN is undefined, zero operands take the full WIDTH+2-cycle latency; results are identical in both builds.

Structure
REQ-027 Package mult_pkg holds the FSM state enum, the default width constant (32) and the Booth-pair encoding constants.
REQ-028 Sub-module booth_step is combinational: it takes acc, the extended multiplicand and the Booth pair, and returns the added/subtracted, shifted {acc, q, q_-1}.
REQ-029 The parent module owns the FSM, step counter, registers and overflow logic.

Verification (WIDTH=32)
REQ-030 Signed -3 x 7 -> result_lo=0xFFFFFFEB, result_hi=0xFFFFFFFF, overflow=0, ready exactly 34 cycles after the start edge.
REQ-031 Signed 0x80000000 x 0xFFFFFFFF -> result_lo=0x80000000, result_hi=0x00000000, overflow=1.
REQ-032 Unsigned 0xFFFFFFFF x 0xFFFFFFFF -> result_lo=0x00000001, result_hi=0xFFFFFFFE, overflow=1; the same operands in signed mode -> result_lo=0x00000001, result_hi=0, overflow=0.
REQ-033 start pulsed with new operands at cycle 10 of a busy operation -> first result is unchanged and no second ready pulse occurs.
REQ-034 reset asserted at cycle 15 of RUN -> no ready pulse, all outputs 0, and a new 6 x 7 then yields result_lo=42.
REQ-035 With BOOTH_ZERO_SKIP_EN, 0 x 0x12345678 -> ready one cycle after the start edge and results 0; without it, ready after 34 cycles and results 0.

Source files
------------

// File: rtl/mult_pkg.sv
// mult_pkg: shared FSM state, default width and Booth-pair encodings for booth_multiplier
package mult_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam int DEFAULT_WIDTH = 32;
  localparam logic [1:0] PAIR_ADD = 2'b01;
  localparam logic [1:0] PAIR_SUB = 2'b10;
endpackage

// File: rtl/booth_step.sv
// booth_step: one radix-2 Booth add/subtract followed by an arithmetic right shift of {acc, q, q_-1}
module booth_step import mult_pkg::*; #(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH:0]       acc,
  input  logic [WIDTH:0]       q,
  input  logic [WIDTH:0]       mcand,
  input  logic [1:0]           pair,
  output logic [2*WIDTH+2:0]   reg_next
);
  logic [WIDTH+1:0] a, m, sum;
  // one guard bit keeps the sum's true sign so the shift-in bit is always correct
  assign a = {acc[WIDTH], acc};
  assign m = {mcand[WIDTH], mcand};
  assign sum = pair == PAIR_SUB ? a - m : pair == PAIR_ADD ? a + m : a;
  assign reg_next = {sum, q};
endmodule

// File: rtl/booth_multiplier.sv
// booth_multiplier: sequential radix-2 Booth multiplier, signed/unsigned, WIDTH+2 cycle latency
// Optional macro BOOTH_ZERO_SKIP_EN: zero operands bypass RUN and finish one cycle after start.
module booth_multiplier import mult_pkg::*; #(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] mult_cand,
  input  logic [WIDTH-1:0] multiplier,
  output logic             busy,
  output logic             ready,
  output logic [WIDTH-1:0] result_lo,
  output logic [WIDTH-1:0] result_hi,
  output logic             overflow
);
  localparam int CW = $clog2(WIDTH + 2);
  localparam logic [CW-1:0] LAST = CW'(WIDTH);
  state_t state, state_next;
  logic [WIDTH:0] acc, q, mcand;
  logic qm1, sgn, zero_op, accept;
  logic [CW-1:0] cnt;
  logic [2*WIDTH+2:0] step;
  logic [WIDTH-1:0] p_lo, p_hi;
`ifdef BOOTH_ZERO_SKIP_EN
  assign zero_op = mult_cand == '0 || multiplier == '0;
`else
  assign zero_op = 1'b0;
`endif
  assign accept = state == IDLE && start;
  assign busy = state != IDLE;
  assign ready = state == DONE;
  booth_step #(.WIDTH(WIDTH)) u_step (
    .acc(acc),
    .q(q),
    .mcand(mcand),
    .pair({q[0], qm1}),
    .reg_next(step)
  );
  // product after the final step, taken straight from the step output so results load on DONE entry
  assign p_lo = step[WIDTH:1];
  assign p_hi = step[2*WIDTH:WIDTH+1];
  always_ff @(posedge clk)
    if (reset) state <= IDLE;
    else state <= state_next;
  always_comb begin
    state_next = state == IDLE ? (start ? (zero_op ? DONE : RUN) : IDLE) :
                 state == RUN  ? (cnt == LAST ? DONE : RUN) : IDLE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      acc <= '0;
      q <= '0;
      qm1 <= 1'b0;
      mcand <= '0;
      sgn <= 1'b0;
      cnt <= '0;
      result_lo <= '0;
      result_hi <= '0;
      overflow <= 1'b0;
    end else if (accept) begin
      acc <= '0;
      q <= {is_signed & multiplier[WIDTH-1], multiplier};
      qm1 <= 1'b0;
      mcand <= {is_signed & mult_cand[WIDTH-1], mult_cand};
      sgn <= is_signed;
      cnt <= '0;
      if (zero_op) begin
        result_lo <= '0;
        result_hi <= '0;
        overflow <= 1'b0;
      end
    end else if (state == RUN) begin
      {acc, q, qm1} <= step;
      cnt <= cnt + CW'(1);
      if (cnt == LAST) begin
        result_lo <= p_lo;
        result_hi <= p_hi;
        overflow <= sgn ? p_hi != {WIDTH{p_lo[WIDTH-1]}} : p_hi != '0;
      end
    end
  end
endmodule

// File: tb/tb_booth_multiplier.sv
// tb_booth_multiplier: randomized self-checking bench against an arithmetic product model
module tb_booth_multiplier;
  localparam int W = 32;
`ifdef BOOTH_ZERO_SKIP_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif
  logic clk = 1'b0;
  logic reset, start, is_signed;
  logic [W-1:0] mult_cand, multiplier, result_lo, result_hi;
  logic busy, ready, overflow;
  int checks = 0;
  int errors = 0;

  booth_multiplier #(.WIDTH(W)) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .is_signed(is_signed),
    .mult_cand(mult_cand),
    .multiplier(multiplier),
    .busy(busy),
    .ready(ready),
    .result_lo(result_lo),
    .result_hi(result_hi),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                                output logic [W-1:0] lo, output logic [W-1:0] hi, output logic ov);
    longint sa, sb, pr;
    logic [63:0] p;
    if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      pr = sa * sb;
      p = 64'(pr);
      ov = pr < -64'sd2147483648 || pr > 64'sd2147483647;
    end else begin
      p = {32'b0, a} * {32'b0, b};
      ov = p > 64'h0000_0000_FFFF_FFFF;
    end
    lo = p[31:0];
    hi = p[63:32];
  endfunction

  function automatic int exp_lat(input logic [W-1:0] a, input logic [W-1:0] b);
    return (SKIP && (a == 0 || b == 0)) ? 1 : W + 2;
  endfunction

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 6))
      0: return '0;
      1: return 32'h8000_0000;
      2: return '1;
      3: return 32'd1;
      default: return W'($urandom);
    endcase
  endfunction

  // issues one op from IDLE; lat is the cycle (1 = first after the start edge) in which ready was seen
  task automatic mult_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                         output logic [W-1:0] lo, output logic [W-1:0] hi, output logic ov, output int lat);
    start = 1'b1;
    mult_cand = a;
    multiplier = b;
    is_signed = s;
    @(posedge clk); #1;
    start = 1'b0;
    mult_cand = W'($urandom);
    multiplier = W'($urandom);
    is_signed = 1'($urandom);
    lat = 1;
    while (!ready && lat < 80) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!ready) lat = -1;
    lo = result_lo;
    hi = result_hi;
    ov = overflow;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    is_signed = 1'b0;
    mult_cand = '0;
    multiplier = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b want 0", ready); end
    checks++; if (result_lo !== '0) begin errors++; $display("FAIL reset_lo got %h want 0", result_lo); end
    checks++; if (result_hi !== '0) begin errors++; $display("FAIL reset_hi got %h want 0", result_hi); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b want 0", overflow); end
    reset = 1'b0;
  endtask

  task automatic test_directed();
    logic [W-1:0] ta [4] = '{32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [W-1:0] tb [4] = '{32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic ts [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
    logic [W-1:0] el [4] = '{32'hFFFF_FFEB, 32'h8000_0000, 32'h0000_0001, 32'h0000_0001};
    logic [W-1:0] eh [4] = '{32'hFFFF_FFFF, 32'h0000_0000, 32'hFFFF_FFFE, 32'h0000_0000};
    logic eo [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    logic [W-1:0] lo, hi;
    logic ov;
    int lat;
    for (int i = 0; i < 4; i++) begin
      mult_op(ta[i], tb[i], ts[i], lo, hi, ov, lat);
      checks++; if (lo !== el[i]) begin errors++; $display("FAIL directed%0d_lo got %h want %h", i, lo, el[i]); end
      checks++; if (hi !== eh[i]) begin errors++; $display("FAIL directed%0d_hi got %h want %h", i, hi, eh[i]); end
      checks++; if (ov !== eo[i]) begin errors++; $display("FAIL directed%0d_ovf got %b want %b", i, ov, eo[i]); end
      checks++; if (lat != W + 2) begin errors++; $display("FAIL directed%0d_latency got %0d want %0d", i, lat, W + 2); end
    end
  endtask

  task automatic test_random();
    logic [W-1:0] a, b, lo, hi, el, eh;
    logic s, ov, eo;
    int lat;
    for (int i = 0; i < 24; i++) begin
      a = pick();
      b = pick();
      s = 1'($urandom);
      model(a, b, s, el, eh, eo);
      mult_op(a, b, s, lo, hi, ov, lat);
      checks++; if (lo !== el || hi !== eh) begin errors++; $display("FAIL random%0d_product got %h_%h want %h_%h", i, hi, lo, eh, el); end
      checks++; if (ov !== eo) begin errors++; $display("FAIL random%0d_ovf got %b want %b", i, ov, eo); end
      checks++; if (lat != exp_lat(a, b)) begin errors++; $display("FAIL random%0d_latency got %0d want %0d", i, lat, exp_lat(a, b)); end
      checks++; if (ready !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL random%0d_pulse got ready=%b busy=%b want 0 0", i, ready, busy); end
      checks++; if (result_lo !== el || result_hi !== eh) begin errors++; $display("FAIL random%0d_hold got %h_%h want %h_%h", i, result_hi, result_lo, eh, el); end
    end
  endtask

  task automatic test_zero();
    logic [W-1:0] lo, hi;
    logic ov;
    int lat;
    mult_op('0, 32'h1234_5678, 1'($urandom), lo, hi, ov, lat);
    checks++; if (lo !== '0 || hi !== '0 || ov !== 1'b0) begin errors++; $display("FAIL zero_a_result got %h_%h ovf=%b want 0", hi, lo, ov); end
    checks++; if (lat != exp_lat('0, 32'h1234_5678)) begin errors++; $display("FAIL zero_a_latency got %0d want %0d", lat, exp_lat('0, 32'h1234_5678)); end
    mult_op(32'hDEAD_BEEF, '0, 1'b1, lo, hi, ov, lat);
    checks++; if (lo !== '0 || hi !== '0 || ov !== 1'b0) begin errors++; $display("FAIL zero_b_result got %h_%h ovf=%b want 0", hi, lo, ov); end
    checks++; if (lat != exp_lat(32'hDEAD_BEEF, '0)) begin errors++; $display("FAIL zero_b_latency got %0d want %0d", lat, exp_lat(32'hDEAD_BEEF, '0)); end
  endtask

  task automatic test_busy_ignore();
    logic [W-1:0] a, b, lo, hi, el, eh;
    logic ov, eo;
    int pulses, lat;
    a = 32'd123456;
    b = -32'sd789;
    model(a, b, 1'b1, el, eh, eo);
    pulses = 0;
    lat = -1;
    start = 1'b1;
    mult_cand = a;
    multiplier = b;
    is_signed = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 1; c <= 80; c++) begin
      if (ready) begin
        pulses++;
        if (pulses == 1) begin lat = c; lo = result_lo; hi = result_hi; ov = overflow; end
      end
      start = c == 10;
      if (c == 10) begin mult_cand = 32'h55; multiplier = 32'h77; is_signed = 1'b0; end
      @(posedge clk); #1;
    end
    checks++; if (pulses != 1) begin errors++; $display("FAIL busy_pulses got %0d want 1", pulses); end
    checks++; if (lat != W + 2) begin errors++; $display("FAIL busy_latency got %0d want %0d", lat, W + 2); end
    checks++; if (lo !== el || hi !== eh || ov !== eo) begin errors++; $display("FAIL busy_result got %h_%h ovf=%b want %h_%h ovf=%b", hi, lo, ov, eh, el, eo); end
    checks++; if (result_lo !== el || result_hi !== eh) begin errors++; $display("FAIL busy_hold got %h_%h want %h_%h", result_hi, result_lo, eh, el); end
  endtask

  task automatic test_reset_abort();
    logic [W-1:0] lo, hi;
    logic ov;
    int pulses, lat;
    pulses = 0;
    start = 1'b1;
    mult_cand = 32'd1000;
    multiplier = 32'd999;
    is_signed = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 1; c <= 60; c++) begin
      if (ready) pulses++;
      if (c == 16) begin
        checks++;
        if (busy !== 1'b0 || ready !== 1'b0 || result_lo !== '0 || result_hi !== '0 || overflow !== 1'b0) begin
          errors++;
          $display("FAIL abort_outputs got busy=%b ready=%b %h_%h ovf=%b want all 0", busy, ready, result_hi, result_lo, overflow);
        end
      end
      reset = c == 15;
      start = c == 15;
      @(posedge clk); #1;
    end
    reset = 1'b0;
    start = 1'b0;
    checks++; if (pulses != 0) begin errors++; $display("FAIL abort_pulses got %0d want 0", pulses); end
    mult_op(32'd6, 32'd7, 1'($urandom), lo, hi, ov, lat);
    checks++; if (lo !== 32'd42 || hi !== '0 || ov !== 1'b0) begin errors++; $display("FAIL abort_after got %h_%h ovf=%b want 0_2a ovf=0", hi, lo, ov); end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] a1, b1, a2, b2, lo1, hi1, lo2, hi2, el, eh;
    logic eo;
    int pulses, r1, r2, idle_cnt;
    a1 = W'($urandom) | 32'h1;
    b1 = W'($urandom) | 32'h1;
    a2 = W'($urandom) | 32'h2;
    b2 = W'($urandom) | 32'h2;
    pulses = 0;
    r1 = 0;
    r2 = 0;
    idle_cnt = 0;
    start = 1'b1;
    mult_cand = a1;
    multiplier = b1;
    is_signed = 1'b1;
    @(posedge clk); #1;
    for (int c = 1; c <= 150 && pulses < 2; c++) begin
      if (pulses == 1 && !busy) idle_cnt++;
      if (ready) begin
        pulses++;
        if (pulses == 1) begin r1 = c; lo1 = result_lo; hi1 = result_hi; mult_cand = a2; multiplier = b2; end
        else begin r2 = c; lo2 = result_lo; hi2 = result_hi; start = 1'b0; end
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (pulses != 2 || r2 - r1 != W + 3) begin errors++; $display("FAIL b2b_spacing got pulses=%0d gap=%0d want 2 %0d", pulses, r2 - r1, W + 3); end
    checks++; if (idle_cnt != 1) begin errors++; $display("FAIL b2b_idle got %0d want 1", idle_cnt); end
    model(a1, b1, 1'b1, el, eh, eo);
    checks++; if (lo1 !== el || hi1 !== eh) begin errors++; $display("FAIL b2b_first got %h_%h want %h_%h", hi1, lo1, eh, el); end
    model(a2, b2, 1'b1, el, eh, eo);
    checks++; if (lo2 !== el || hi2 !== eh) begin errors++; $display("FAIL b2b_second got %h_%h want %h_%h", hi2, lo2, eh, el); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_zero();
    test_busy_ignore();
    test_reset_abort();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
